// File: rtl/rand_tile_spawner.sv
// Random empty-cell picker for the tile game: a free-running XNOR Fibonacci LFSR supplies
// random probes into a latched empty-cell mask, with a deterministic scan as a bounded fallback.
module rand_tile_spawner #(
  parameter int unsigned LFSR_W      = 32,
  parameter logic [31:0] SEED        = 32'hACE12048,
  parameter int unsigned GRID_N      = 4,
  parameter int unsigned FOUR_THRESH = 25,
  parameter int unsigned MAX_TRIES   = 16,
  localparam int unsigned CW         = $clog2(GRID_N),
  localparam int unsigned NC         = GRID_N * GRID_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  input  logic              req,
  input  logic [NC-1:0]     empty_mask,
  output logic              busy,
  output logic              valid,
  output logic [CW-1:0]     x_coor,
  output logic [CW-1:0]     y_coor,
  output logic              tile_val,
  output logic              fail,
  output logic [LFSR_W-1:0] rnd
);

  localparam int unsigned IW = 2 * CW;
  localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [LFSR_W-1:0] SeedW    = SEED[LFSR_W-1:0];
  localparam logic [TW-1:0]     LastTry  = TW'(MAX_TRIES - 1);
  localparam logic [7:0]        FourThr  = 8'(FOUR_THRESH);

  // 1-based feedback taps for the supported maximal-length widths
  localparam int unsigned Tap1 = LFSR_W;
  localparam int unsigned Tap2 = (LFSR_W == 8)  ? 6  :
                                 (LFSR_W == 16) ? 15 :
                                 (LFSR_W == 24) ? 23 : 22;
  localparam int unsigned Tap3 = (LFSR_W == 8)  ? 5  :
                                 (LFSR_W == 16) ? 13 :
                                 (LFSR_W == 24) ? 22 : 2;
  localparam int unsigned Tap4 = (LFSR_W == 8)  ? 4  :
                                 (LFSR_W == 16) ? 4  :
                                 (LFSR_W == 24) ? 17 : 1;

  typedef enum logic [1:0] {StIdle, StSample, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] rnd_q;
  logic [NC-1:0]     mask_q, mask_d;
  logic [TW-1:0]     tries_q, tries_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     x_q, x_d, y_q, y_d;
  logic              tile_q, tile_d, fail_q, fail_d;

  logic              fb;
  logic [IW-1:0]     idx;
  logic              four;

  // XNOR feedback: all-ones is the lock-up state and is never reached from a legal seed
  assign fb   = ~(rnd_q[Tap1-1] ^ rnd_q[Tap2-1] ^ rnd_q[Tap3-1] ^ rnd_q[Tap4-1]);
  assign idx  = rnd_q[IW-1:0];
  assign four = rnd_q[LFSR_W-1 -: 8] < FourThr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q <= SeedW;
    end else if (seed_load) begin
      rnd_q <= (&seed_val) ? SeedW : seed_val;
    end else begin
      rnd_q <= {rnd_q[LFSR_W-2:0], fb};
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    ptr_d   = ptr_q;
    x_d     = x_q;
    y_d     = y_q;
    tile_d  = tile_q;
    fail_d  = fail_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          mask_d  = empty_mask;
          tries_d = '0;
          if (empty_mask == '0) begin
            fail_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StSample;
          end
        end
      end
      StSample: begin
        if (mask_q[idx]) begin
          x_d     = idx[CW-1:0];
          y_d     = idx[IW-1:CW];
          tile_d  = four;
          fail_d  = 1'b0;
          state_d = StDone;
        end else if (tries_q == LastTry) begin
          ptr_d   = idx;
          state_d = StScan;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      StScan: begin
        // Mask is known non-zero here, so the wrapping walk always terminates
        if (mask_q[ptr_q]) begin
          x_d     = ptr_q[CW-1:0];
          y_d     = ptr_q[IW-1:CW];
          tile_d  = four;
          fail_d  = 1'b0;
          state_d = StDone;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      tries_q <= '0;
      ptr_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      tile_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      ptr_q   <= ptr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tile_q  <= tile_d;
      fail_q  <= fail_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign valid    = (state_q == StDone);
  assign x_coor   = x_q;
  assign y_coor   = y_q;
  assign tile_val = tile_q;
  assign fail     = fail_q;
  assign rnd      = rnd_q;

endmodule

// File: tb/tb_rand_tile_spawner.sv
// Directed bench for rand_tile_spawner: vector table plus hand sequences for reset, seeding,
// mask latching, LFSR period (8-bit instance) and spawn distribution.
module tb_rand_tile_spawner;

  localparam logic [31:0] SEED = 32'hACE12048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed_val = '0;
  logic        req = 1'b0;
  logic [15:0] empty_mask = '0;
  logic        busy, valid, tile_val, fail;
  logic [1:0]  x_coor, y_coor;
  logic [31:0] rnd;

  logic        seed_load8 = 1'b0;
  logic [7:0]  seed_val8 = '0;
  logic        req8 = 1'b0;
  logic [3:0]  mask8 = '0;
  logic        busy8, valid8, tile8, fail8;
  logic [0:0]  x8, y8;
  logic [7:0]  rnd8;

  always #5 clk = ~clk;

  rand_tile_spawner u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .req        (req),
    .empty_mask (empty_mask),
    .busy       (busy),
    .valid      (valid),
    .x_coor     (x_coor),
    .y_coor     (y_coor),
    .tile_val   (tile_val),
    .fail       (fail),
    .rnd        (rnd)
  );

  // Narrow instance used only to exercise the 8-bit LFSR period
  rand_tile_spawner #(
    .LFSR_W (8),
    .GRID_N (2)
  ) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load8),
    .seed_val   (seed_val8),
    .req        (req8),
    .empty_mask (mask8),
    .busy       (busy8),
    .valid      (valid8),
    .x_coor     (x8),
    .y_coor     (y8),
    .tile_val   (tile8),
    .fail       (fail8),
    .rnd        (rnd8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rnd_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent 32-bit reference LFSR, taps 32,22,2,1
  function automatic logic [31:0] lfsr32(input logic [31:0] r);
    return {r[30:0], ~(r[31] ^ r[21] ^ r[1] ^ r[0])};
  endfunction

  logic [31:0] m_rnd, m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rnd  <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_rnd;
      if (seed_load) m_rnd <= (seed_val == 32'hFFFF_FFFF) ? SEED : seed_val;
      else           m_rnd <= lfsr32(m_rnd);
    end
  end

  always @(negedge clk) if (rnd !== m_rnd) rnd_bad++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_val  = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // Called just after the accepting edge; lat counts edges from that edge to the valid sample
  task automatic wait_valid(output int lat, output bit got);
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 40) begin
      if (valid) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [15:0] mask;
    bit          full;
    bit          exp_fail;
    logic [1:0]  ex;
    logic [1:0]  ey;
  } vec_t;

  vec_t vt[8];

  initial begin
    int   lat;
    bit   got;
    bit   et;
    logic [1:0] ex, ey, last_ex, last_ey;
    int   hits[16];
    int   tiles, nv, cyc, failv, hmin, hmax, ff_seen, early;
    logic [7:0] r255;
    bit   reached;

    vt[0] = '{32'h1234_5678, 16'h0400, 1'b0, 1'b0, 2'd2, 2'd2};
    vt[1] = '{32'hFFFF_FFFF, 16'h0001, 1'b0, 1'b0, 2'd0, 2'd0};
    vt[2] = '{32'hDEAD_BEEF, 16'h8000, 1'b0, 1'b0, 2'd3, 2'd3};
    vt[3] = '{32'h0000_0001, 16'h0000, 1'b0, 1'b1, 2'd0, 2'd0};
    vt[4] = '{32'hCAFE_F00D, 16'h0010, 1'b0, 1'b0, 2'd0, 2'd1};
    vt[5] = '{32'h0BAD_C0DE, 16'h0008, 1'b0, 1'b0, 2'd3, 2'd0};
    vt[6] = '{32'h1357_9BDF, 16'hFFFF, 1'b1, 1'b0, 2'd0, 2'd0};
    vt[7] = '{32'hFFFF_FFFF, 16'h0200, 1'b0, 1'b0, 2'd1, 2'd2};

    // Reset values
    #12;
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fail", fail, 1'b0);
    check("rst_xy", {x_coor, y_coor}, 4'h0);
    check("rst_tile", tile_val, 1'b0);
    check("rst_rnd", rnd, SEED);
    check("rst_rnd8", rnd8, 8'h48);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("first_shift", rnd, 32'h59C2_4091);

    // Seed all-ones falls back to SEED
    load_seed(32'hFFFF_FFFF);
    check("seed_ones", rnd, SEED);
    load_seed(32'h0000_00A5);
    check("seed_plain", rnd, 32'h0000_00A5);

    // Vector table
    last_ex = 2'd0;
    last_ey = 2'd0;
    for (int i = 0; i < 8; i++) begin
      load_seed(vt[i].seed);
      empty_mask = vt[i].mask;
      req = 1'b1;
      tick();
      req = 1'b0;
      wait_valid(lat, got);
      check($sformatf("v%0d_valid", i), got, 1'b1);
      check($sformatf("v%0d_fail", i), fail, vt[i].exp_fail);
      if (vt[i].exp_fail) begin
        check($sformatf("v%0d_lat", i), lat, 1);
        check($sformatf("v%0d_hold_xy", i), {x_coor, y_coor}, {last_ex, last_ey});
      end else begin
        ex = vt[i].full ? m_prev[1:0] : vt[i].ex;
        ey = vt[i].full ? m_prev[3:2] : vt[i].ey;
        et = (m_prev[31:24] < 8'd25);
        check($sformatf("v%0d_lat_ok", i), (lat >= 2 && lat <= 33), 1'b1);
        if (vt[i].full) check($sformatf("v%0d_lat_full", i), lat, 2);
        check($sformatf("v%0d_x", i), x_coor, ex);
        check($sformatf("v%0d_y", i), y_coor, ey);
        check($sformatf("v%0d_tile", i), tile_val, et);
        last_ex = ex;
        last_ey = ey;
      end
      tick();
      check($sformatf("v%0d_idle", i), {busy, valid}, 2'b00);
    end

    // Board full: valid right after acceptance, then idle
    empty_mask = 16'h0000;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("full_valid", valid, 1'b1);
    check("full_fail", fail, 1'b1);
    check("full_busy", busy, 1'b1);
    tick();
    check("full_after", {busy, valid}, 2'b00);

    // Mask cleared after acceptance must not matter
    empty_mask = 16'h0400;
    req = 1'b1;
    tick();
    req = 1'b0;
    empty_mask = 16'h0000;
    wait_valid(lat, got);
    check("latch_valid", got, 1'b1);
    check("latch_lat", (lat <= 33), 1'b1);
    check("latch_xyf", {x_coor, y_coor, fail}, {2'd2, 2'd2, 1'b0});
    tick();

    // Seed fallback while sampling leaves the FSM running
    empty_mask = 16'h0001;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("smp_state", {busy, valid}, 2'b10);
    seed_val  = 32'hFFFF_FFFF;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("smp_seed", rnd, SEED);
    wait_valid(lat, got);
    check("smp_valid", got, 1'b1);
    check("smp_xyf", {x_coor, y_coor, fail}, 5'b0);
    tick();

    // 8-bit LFSR period from seed 0x01
    seed_val8  = 8'h01;
    seed_load8 = 1'b1;
    tick();
    seed_load8 = 1'b0;
    check("p8_load", rnd8, 8'h01);
    ff_seen = 0;
    early = 0;
    r255 = 8'h00;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (rnd8 == 8'hFF) ff_seen++;
      if (rnd8 == 8'h01 && k < 255) early++;
      if (k == 255) r255 = rnd8;
    end
    check("p8_no_ff", ff_seen, 0);
    check("p8_early", early, 0);
    check("p8_period", r255, 8'h01);

    // Distribution with req held high: back-to-back 3-cycle spawns
    foreach (hits[j]) hits[j] = 0;
    tiles = 0;
    nv = 0;
    cyc = 0;
    failv = 0;
    load_seed($urandom);
    empty_mask = 16'hFFFF;
    req = 1'b1;
    while (nv < 3200 && cyc < 20000) begin
      if (valid) begin
        hits[int'({y_coor, x_coor})]++;
        tiles += int'(tile_val);
        if (fail) failv++;
        nv++;
      end
      tick();
      cyc++;
    end
    req = 1'b0;
    hmin = hits[0];
    hmax = hits[0];
    foreach (hits[j]) begin
      if (hits[j] < hmin) hmin = hits[j];
      if (hits[j] > hmax) hmax = hits[j];
    end
    check("dist_count", nv, 3200);
    check("dist_rate", cyc, 9600);
    check("dist_fail", failv, 0);
    check("dist_min", (hmin >= 140), 1'b1);
    check("dist_max", (hmax <= 260), 1'b1);
    check("dist_four", (tiles >= 266 && tiles <= 361), 1'b1);
    tick();
    tick();

    // Drive into the scan fallback, then reset mid-scan
    reached = 1'b0;
    for (int a = 0; a < 40 && !reached; a++) begin
      bit hit;
      int cnt;
      load_seed(32'h0000_1000 + 32'(a) * 32'd7919);
      empty_mask = 16'h0001;
      req = 1'b1;
      tick();
      req = 1'b0;
      hit = 1'b0;
      cnt = 0;
      while (cnt < 17) begin
        if (valid) hit = 1'b1;
        tick();
        cnt++;
      end
      if (valid) hit = 1'b1;
      if (!hit && busy) reached = 1'b1;
      else if (busy) begin
        tick();
        tick();
      end
    end
    check("reach_scan", reached, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {valid, busy, fail, tile_val, x_coor, y_coor}, 8'h00);
    check("mid_rst_rnd", rnd, SEED);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst_shift", rnd, 32'h59C2_4091);
    check("mid_rst_idle", {busy, valid}, 2'b00);

    check("rnd_stream", rnd_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
